// File: rtl/bcd_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Package : bcd_pkg                                                  |
// | Shared BCD limits, state encodings and single-step helper.        |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package bcd_pkg;

  localparam logic [3:0] BCD_MIN = 4'd0;
  localparam logic [3:0] BCD_MAX = 4'd9;

  localparam logic [3:0] S0 = 4'd0;
  localparam logic [3:0] S1 = 4'd1;
  localparam logic [3:0] S2 = 4'd2;
  localparam logic [3:0] S3 = 4'd3;
  localparam logic [3:0] S4 = 4'd4;
  localparam logic [3:0] S5 = 4'd5;
  localparam logic [3:0] S6 = 4'd6;
  localparam logic [3:0] S7 = 4'd7;
  localparam logic [3:0] S8 = 4'd8;
  localparam logic [3:0] S9 = 4'd9;

  // One step around the 0..9 ring; encodings above 9 fall back to S0.
  function automatic logic [3:0] bcd_next(input logic [3:0] s, input logic up);
    logic [3:0] n;
    n = S0;
    case (s)
      S0: n = up ? S1 : S9;
      S1: n = up ? S2 : S0;
      S2: n = up ? S3 : S1;
      S3: n = up ? S4 : S2;
      S4: n = up ? S5 : S3;
      S5: n = up ? S6 : S4;
      S6: n = up ? S7 : S5;
      S7: n = up ? S8 : S6;
      S8: n = up ? S9 : S7;
      S9: n = up ? S0 : S8;
      default: n = S0;
    endcase
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_sync.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : debounce_sync                                            |
// | Two-flop synchroniser, stability-count debouncer, rise detector.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module debounce_sync #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_s1;
  logic             r_s2;
  logic             r_deb;
  logic             r_deb_q;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_deb   <= 1'b0;
      r_deb_q <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_s1    <= raw;
      r_s2    <= r_s1;
      r_deb_q <= r_deb;
      // Any sample agreeing with the current level restarts the stability run.
      if (r_s2 == r_deb) begin
        r_cnt <= '0;
      end else if (r_cnt == c_last_cnt) begin
        r_deb <= r_s2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign level = r_deb;
  assign rise  = r_deb & ~r_deb_q;

endmodule
`default_nettype wire

// File: rtl/bcd_step_counter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : bcd_step_counter                                         |
// | Debounced pushbutton steps a Moore BCD digit up/down with wrap.   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module bcd_step_counter
  import bcd_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic step,
  input  logic dir,
  input  logic hold,
  output logic A,
  output logic B,
  output logic C,
  output logic D,
  output logic wrap
);

  logic       w_level;
  logic       w_rise;
  logic       w_ev;
  logic [3:0] r_state;
  logic [3:0] w_state_nxt;
  logic       r_wrap;
  logic       w_wrap_nxt;

  debounce_sync #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_deb (
    .clk   (clk),
    .rst   (rst),
    .raw   (step),
    .level (w_level),
    .rise  (w_rise)
  );

  assign w_ev = w_rise & w_level;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S0;
      r_wrap  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_wrap  <= w_wrap_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wrap_nxt  = 1'b0;
    if (r_state > BCD_MAX) begin
      w_state_nxt = S0;
    end else if (w_ev && !hold) begin
      w_state_nxt = bcd_next(r_state, dir);
      w_wrap_nxt  = dir ? (r_state == BCD_MAX) : (r_state == BCD_MIN);
    end
  end

  always_comb begin
    {A, B, C, D} = r_state;
    wrap         = r_wrap;
  end

endmodule
`default_nettype wire
